req_master: RTL

- Bus master stage directly downstream of the LFSR request generator. Consumes its random one-cycle `rq` pulses and queues them as pending transactions.
- Requests the bus from the arbiter with a req/gnt handshake. Once granted, drives a fixed-length data burst, then releases the bus.
- Several instances, each with its own LFSR, feed the bus arbiter in the system and testbench.

---
 rtl/req_master_pkg.sv | 22 ++
 rtl/req_master_if.sv | 41 ++++
 rtl/sat_updown_cnt.sv | 34 +++
 rtl/req_master.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/req_master_pkg.sv
// Shared definitions for req_master and its testbenches: FSM encoding,
// default sizing and a small width helper.
package req_master_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_XFER = 2'd2;
    localparam state_t ST_REL  = 2'd3;

    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_PEND_W    = 3;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_TIMEOUT   = 16;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/req_master_if.sv
// Request/grant/burst bundle between the LFSR source, req_master and the
// bus arbiter side.
interface req_master_if
    import req_master_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PEND_W = DEF_PEND_W
);

    logic              rq_in;
    logic              gnt;
    logic              req;
    logic              data_valid;
    logic [DATA_W-1:0] data_out;
    logic [PEND_W-1:0] pend_cnt;
    logic              overflow;
    logic              xfer_abort;

    modport master (
        input  rq_in,
        input  gnt,
        output req,
        output data_valid,
        output data_out,
        output pend_cnt,
        output overflow,
        output xfer_abort
    );

    modport slave (
        output rq_in,
        output gnt,
        input  req,
        input  data_valid,
        input  data_out,
        input  pend_cnt,
        input  overflow,
        input  xfer_abort
    );

endinterface

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter with a sticky overflow flag that records any
// increment attempted while the count is already at its maximum.
module sat_updown_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         overflow
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            // inc and dec together cancel, even at the saturation point
            if (inc && !dec) begin
                if (cnt == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (dec && !inc && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_master.sv
// Bus master: queues LFSR request pulses, requests the bus, drives a fixed
// burst per grant and releases. Optional REQ_TIMEOUT_EN aborts a stalled request.
module req_master
    import req_master_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int PEND_W    = DEF_PEND_W,
    parameter int DATA_W    = DEF_DATA_W
`ifdef REQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = DEF_TIMEOUT
`endif
) (
    input  logic         clk,
    input  logic         rst,
    req_master_if.master bus
);

    localparam int                BEAT_W    = cnt_w(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    state_t            state_reg, state_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic [DATA_W-1:0] txn_id_reg, txn_id_next;
    logic              req_reg, req_next;
    logic              data_valid_reg, data_valid_next;
    logic [DATA_W-1:0] data_out_reg, data_out_next;
    logic              xfer_abort_reg, xfer_abort_next;

    logic [PEND_W-1:0] pend_cnt;
    logic              overflow;
    logic              grant_accept;
    logic              burst_abort;
    logic              timeout_hit;

`ifdef REQ_TIMEOUT_EN
    localparam int                WAIT_W    = cnt_w(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_reg, wait_next;
`endif

    sat_updown_cnt #(
        .W (PEND_W)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .inc      (bus.rq_in),
        .dec      (grant_accept | timeout_hit),
        .cnt      (pend_cnt),
        .overflow (overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            beat_reg       <= '0;
            txn_id_reg     <= '0;
            req_reg        <= 1'b0;
            data_valid_reg <= 1'b0;
            data_out_reg   <= '0;
            xfer_abort_reg <= 1'b0;
`ifdef REQ_TIMEOUT_EN
            wait_reg       <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            beat_reg       <= beat_next;
            txn_id_reg     <= txn_id_next;
            req_reg        <= req_next;
            data_valid_reg <= data_valid_next;
            data_out_reg   <= data_out_next;
            xfer_abort_reg <= xfer_abort_next;
`ifdef REQ_TIMEOUT_EN
            wait_reg       <= wait_next;
`endif
        end
    end

    // The current rq_in already counts toward leaving IDLE, so req rises
    // one cycle after the first pulse even though pend_cnt still reads 0.
    always_comb begin
        state_next   = state_reg;
        grant_accept = 1'b0;
        burst_abort  = 1'b0;
        timeout_hit  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pend_cnt != '0 || bus.rq_in) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.gnt) begin
                    grant_accept = 1'b1;
                    state_next   = ST_XFER;
                end
`ifdef REQ_TIMEOUT_EN
                else if (wait_reg == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_REL;
                end
`endif
            end
            ST_XFER: begin
                // A lost grant ends the burst at once, even on the last beat
                if (!bus.gnt) begin
                    burst_abort = 1'b1;
                    state_next  = ST_REL;
                end else if (beat_reg == LAST_BEAT) begin
                    state_next = ST_REL;
                end
            end
            ST_REL: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered values
    // line up with the state they describe.
    always_comb begin
        beat_next       = (state_reg == ST_XFER && state_next == ST_XFER) ? beat_reg + 1'b1 : '0;
        txn_id_next     = (state_reg == ST_XFER && state_next == ST_REL) ? txn_id_reg + 1'b1 : txn_id_reg;
        req_next        = (state_next == ST_REQ) || (state_next == ST_XFER);
        data_valid_next = (state_next == ST_XFER);
        data_out_next   = data_valid_next ? txn_id_reg + DATA_W'(beat_next) : '0;
        xfer_abort_next = burst_abort | timeout_hit;
`ifdef REQ_TIMEOUT_EN
        wait_next       = (state_reg == ST_REQ && state_next == ST_REQ) ? wait_reg + 1'b1 : '0;
`endif
    end

    assign bus.req        = req_reg;
    assign bus.data_valid = data_valid_reg;
    assign bus.data_out   = data_out_reg;
    assign bus.pend_cnt   = pend_cnt;
    assign bus.overflow   = overflow;
    assign bus.xfer_abort = xfer_abort_reg;

endmodule
